// File: rtl/wb_grf_writeback.sv
`default_nettype none
//==============================================================================
// Module      : wb_grf_writeback
// Description : Write-back stage.
//               - Decodes the W-stage instruction and selects the result.
//               - Writes the result into a 32x32 register file ($0 hardwired).
//               - Provides two D-stage read ports with same-cycle W->D bypass.
//               - Exports the write triple for forwarding.
//               - Tracks the retired-instruction count and the last retired PC.
//               Optional macro GRF_TRACE_EN prints one line per committed
//               register write.
// Revision    : 1.0 - initial release
//==============================================================================
module wb_grf_writeback #(
  parameter logic [31:0] PC_RESET = 32'h00003000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_Instr,
  input  logic [31:0] W_PC,
  input  logic [31:0] W_ALUResult,
  input  logic [31:0] W_EXTResult,
  input  logic [31:0] W_MemReadData,
  input  logic [31:0] W_ReadByteData,
  input  logic [4:0]  D_RsAddr,
  input  logic [4:0]  D_RtAddr,
  output logic [31:0] D_RsData,
  output logic [31:0] D_RtData,
  output logic        W_WriteEn,
  output logic [4:0]  W_WriteAddr,
  output logic [31:0] W_WriteData,
  output logic [31:0] RetireCount,
  output logic [31:0] LastPC
);

  localparam logic [5:0] c_OP_SPECIAL = 6'h00;
  localparam logic [5:0] c_OP_ORI     = 6'h0d;
  localparam logic [5:0] c_OP_LUI     = 6'h0f;
  localparam logic [5:0] c_OP_LW      = 6'h23;
  localparam logic [5:0] c_OP_LB      = 6'h20;
  localparam logic [5:0] c_OP_JAL     = 6'h03;
  localparam logic [5:0] c_FN_ADDU    = 6'h21;
  localparam logic [5:0] c_FN_SUBU    = 6'h23;
  localparam logic [4:0] c_RA         = 5'd31;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic        w_dec_we;
  logic [4:0]  w_dec_addr;
  logic [31:0] w_dec_data;
  logic [31:0] r_regs [NUM_REGS];
  logic [31:0] r_retire_count;
  logic [31:0] r_last_pc;

  assign w_opcode = W_Instr[31:26];
  assign w_rt     = W_Instr[20:16];
  assign w_rd     = W_Instr[15:11];
  assign w_funct  = W_Instr[5:0];

  // Decode the destination register and pick the result source.
  always_comb begin
    w_dec_we   = 1'b0;
    w_dec_addr = 5'd0;
    w_dec_data = 32'd0;
    case (w_opcode)
      c_OP_SPECIAL: begin
        if (w_funct == c_FN_ADDU || w_funct == c_FN_SUBU) begin
          w_dec_we   = 1'b1;
          w_dec_addr = w_rd;
          w_dec_data = W_ALUResult;
        end
      end
      c_OP_ORI: begin
        w_dec_we   = 1'b1;
        w_dec_addr = w_rt;
        w_dec_data = W_ALUResult;
      end
      c_OP_LUI: begin
        w_dec_we   = 1'b1;
        w_dec_addr = w_rt;
        w_dec_data = W_EXTResult;
      end
      c_OP_LW: begin
        w_dec_we   = 1'b1;
        w_dec_addr = w_rt;
        w_dec_data = W_MemReadData;
      end
      c_OP_LB: begin
        w_dec_we   = 1'b1;
        w_dec_addr = w_rt;
        w_dec_data = W_ReadByteData;
      end
      c_OP_JAL: begin
        w_dec_we   = 1'b1;
        w_dec_addr = c_RA;
        w_dec_data = W_PC + 32'd8;
      end
      default: begin
        w_dec_we   = 1'b0;
      end
    endcase
  end

  // Writes to $0 and writes while in reset are suppressed at the source, so
  // the forwarding unit never sees a phantom producer.
  assign W_WriteEn   = reset & w_dec_we & (w_dec_addr != 5'd0);
  assign W_WriteAddr = W_WriteEn ? w_dec_addr : 5'd0;
  assign W_WriteData = W_WriteEn ? w_dec_data : 32'd0;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
      if (i == 0) begin : g_zero
        assign r_regs[i] = 32'd0;
      end else begin : g_reg
        // One register: async clear, load when it is the write target.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            r_regs[i] <= 32'd0;
          end else if (W_WriteEn && (W_WriteAddr == 5'(i))) begin
            r_regs[i] <= W_WriteData;
          end
        end
      end
    end
  endgenerate

  // Read port 1: zero for $0 or reset, bypass on address match, else array.
  always_comb begin
    D_RsData = 32'd0;
    if (!reset || D_RsAddr == 5'd0) begin
      D_RsData = 32'd0;
    end else if (W_WriteEn && D_RsAddr == W_WriteAddr) begin
      D_RsData = W_WriteData;
    end else if (int'(D_RsAddr) < NUM_REGS) begin
      D_RsData = r_regs[D_RsAddr];
    end
  end

  // Read port 2: same priority as port 1, both may bypass together.
  always_comb begin
    D_RtData = 32'd0;
    if (!reset || D_RtAddr == 5'd0) begin
      D_RtData = 32'd0;
    end else if (W_WriteEn && D_RtAddr == W_WriteAddr) begin
      D_RtData = W_WriteData;
    end else if (int'(D_RtAddr) < NUM_REGS) begin
      D_RtData = r_regs[D_RtAddr];
    end
  end

  // Retire tracking: every non-nop instruction leaving W counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retire_count <= 32'd0;
      r_last_pc      <= PC_RESET;
    end else if (W_Instr != 32'd0) begin
      r_retire_count <= r_retire_count + 32'd1;
      r_last_pc      <= W_PC;
    end
  end

  assign RetireCount = r_retire_count;
  assign LastPC      = r_last_pc;

`ifdef GRF_TRACE_EN
  // Commit trace; W_WriteEn already excludes $0 and reset-low cycles.
  always @(posedge clk) begin
    if (reset && W_WriteEn) begin
      $display("@%h: $%d <= %h", W_PC, W_WriteAddr, W_WriteData);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_grf_writeback.sv
`default_nettype none
//==============================================================================
// Module      : tb_wb_grf_writeback
// Description : Scoreboard bench for wb_grf_writeback. Stimulus drives one
//               W-stage instruction per cycle and queues the expected
//               outputs; the monitor drains the queue on every falling edge
//               (or on demand right after an asynchronous reset).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_wb_grf_writeback;

  localparam int c_F_RS  = 0;
  localparam int c_F_RT  = 1;
  localparam int c_F_WE  = 2;
  localparam int c_F_WA  = 3;
  localparam int c_F_WD  = 4;
  localparam int c_F_RC  = 5;
  localparam int c_F_LPC = 6;

  typedef struct {
    int          fld;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] W_Instr, W_PC, W_ALUResult, W_EXTResult, W_MemReadData, W_ReadByteData;
  logic [4:0]  D_RsAddr, D_RtAddr;
  logic [31:0] D_RsData, D_RtData;
  logic        W_WriteEn;
  logic [4:0]  W_WriteAddr;
  logic [31:0] W_WriteData;
  logic [31:0] RetireCount, LastPC;

  exp_t        q_exp[$];
  event        ev_sample;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Retire model: count of non-nop instructions that crossed an edge in reset-high.
  logic [31:0] m_rc;
  logic [31:0] m_lpc;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;

  wb_grf_writeback #(
    .PC_RESET (32'h00003000),
    .NUM_REGS (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .W_Instr        (W_Instr),
    .W_PC           (W_PC),
    .W_ALUResult    (W_ALUResult),
    .W_EXTResult    (W_EXTResult),
    .W_MemReadData  (W_MemReadData),
    .W_ReadByteData (W_ReadByteData),
    .D_RsAddr       (D_RsAddr),
    .D_RtAddr       (D_RtAddr),
    .D_RsData       (D_RsData),
    .D_RtData       (D_RtData),
    .W_WriteEn      (W_WriteEn),
    .W_WriteAddr    (W_WriteAddr),
    .W_WriteData    (W_WriteData),
    .RetireCount    (RetireCount),
    .LastPC         (LastPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk or ev_sample);
      while (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        case (e.fld)
          c_F_RS:  act = D_RsData;
          c_F_RT:  act = D_RtData;
          c_F_WE:  act = {31'd0, W_WriteEn};
          c_F_WA:  act = {27'd0, W_WriteAddr};
          c_F_WD:  act = W_WriteData;
          c_F_RC:  act = RetireCount;
          default: act = LastPC;
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input int f, input logic [31:0] v, input string n);
    exp_t e;
    e.fld  = f;
    e.exp  = v;
    e.name = n;
    q_exp.push_back(e);
  endtask

  task automatic expect_retire(input string n);
    expect_val(c_F_RC,  m_rc,  {n, "_rc"});
    expect_val(c_F_LPC, m_lpc, {n, "_lpc"});
  endtask

  task automatic expect_write(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input string n);
    expect_val(c_F_WE, {31'd0, we}, {n, "_we"});
    expect_val(c_F_WA, {27'd0, wa}, {n, "_wa"});
    expect_val(c_F_WD, wd,          {n, "_wd"});
  endtask

  // Present a new W-stage bundle; first retire the one that just crossed the edge.
  task automatic apply(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] ext,
                       input logic [31:0] mem, input logic [31:0] bytev,
                       input logic [4:0] rs, input logic [4:0] rt);
    if (prev_instr != 32'd0) begin
      m_rc  = m_rc + 32'd1;
      m_lpc = prev_pc;
    end
    prev_instr     = instr;
    prev_pc        = pc;
    W_Instr        = instr;
    W_PC           = pc;
    W_ALUResult    = alu;
    W_EXTResult    = ext;
    W_MemReadData  = mem;
    W_ReadByteData = bytev;
    D_RsAddr       = rs;
    D_RtAddr       = rt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    m_rc = 32'd0; m_lpc = 32'h00003000; prev_instr = 32'd0; prev_pc = 32'd0;
    apply(32'h34011234, 32'h00003000, 32'h1234, 32'd0, 32'd0, 32'd0, 5'd1, 5'd1);
    prev_instr = 32'd0;
    next_cycle();
    next_cycle();
    // In reset: an ori is presented but must be invisible and uncommitted.
    expect_val(c_F_RS, 32'd0, "inrst_rs");
    expect_val(c_F_RT, 32'd0, "inrst_rt");
    expect_write(1'b0, 5'd0, 32'd0, "inrst");
    expect_retire("inrst");
    next_cycle();

    reset = 1'b1;
    // Sweep all 32 registers through both ports: all zero after reset.
    for (int i = 0; i < 16; i++) begin
      apply(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'(i), 5'(i + 16));
      expect_val(c_F_RS, 32'd0, "rst_rs");
      expect_val(c_F_RT, 32'd0, "rst_rt");
      expect_retire("rst");
      next_cycle();
    end

    // ori $1,$0,0x1234 with bypass.
    apply(32'h34011234, 32'h00003000, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0);
    expect_val(c_F_RS, 32'h1234, "ori_byp");
    expect_write(1'b1, 5'd1, 32'h1234, "ori");
    expect_retire("ori");
    next_cycle();

    // jal at 0x3010; ALU result is a decoy.
    apply(32'h0C000C08, 32'h00003010, 32'hBAD0BAD0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd31);
    expect_val(c_F_RS, 32'h1234, "ori_reg");
    expect_val(c_F_RT, 32'h00003018, "jal_byp");
    expect_write(1'b1, 5'd31, 32'h00003018, "jal");
    expect_retire("jal");
    next_cycle();

    // lb $2 with a negative byte; lw data is a decoy.
    apply(32'h80020000, 32'h00003014, 32'h0, 32'h0, 32'h11111111, 32'hFFFFFF80, 5'd31, 5'd2);
    expect_val(c_F_RS, 32'h00003018, "jal_reg");
    expect_val(c_F_RT, 32'hFFFFFF80, "lb_byp");
    expect_write(1'b1, 5'd2, 32'hFFFFFF80, "lb");
    expect_retire("lb");
    next_cycle();

    // addu $0,$1,$2: must not write.
    apply(32'h00220021, 32'h00003018, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 5'd0, 5'd2);
    expect_val(c_F_RS, 32'd0, "addu0_rs");
    expect_val(c_F_RT, 32'hFFFFFF80, "lb_reg");
    expect_write(1'b0, 5'd0, 32'd0, "addu0");
    expect_retire("addu0");
    next_cycle();

    // sw and beq: no write, but each retires.
    apply(32'hAC010004, 32'h0000301C, 32'h55555555, 32'h0, 32'h0, 32'h0, 5'd0, 5'd1);
    expect_val(c_F_RS, 32'd0, "zero_after_addu0");
    expect_write(1'b0, 5'd0, 32'd0, "sw");
    expect_retire("sw");
    next_cycle();
    apply(32'h10220003, 32'h00003020, 32'h00000001, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2);
    expect_write(1'b0, 5'd0, 32'd0, "beq");
    expect_retire("beq");
    next_cycle();
    apply(32'd0, 32'h00003024, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2);
    expect_val(c_F_RS, 32'h1234, "after_sw_r1");
    expect_val(c_F_RT, 32'hFFFFFF80, "after_beq_r2");
    expect_retire("after_beq");
    next_cycle();

    // subu $4,$1,$2.
    apply(32'h00222023, 32'h00003028, 32'h12345678, 32'h0, 32'h0, 32'h0, 5'd4, 5'd0);
    expect_val(c_F_RS, 32'h12345678, "subu_byp");
    expect_write(1'b1, 5'd4, 32'h12345678, "subu");
    next_cycle();

    // lui $3 then lw $3 back to back, RT tracking each.
    apply(32'h3C03ABCD, 32'h0000302C, 32'h0, 32'hABCD0000, 32'h0, 32'h0, 5'd4, 5'd3);
    expect_val(c_F_RS, 32'h12345678, "subu_reg");
    expect_val(c_F_RT, 32'hABCD0000, "lui_byp");
    expect_write(1'b1, 5'd3, 32'hABCD0000, "lui");
    next_cycle();
    apply(32'h8C030000, 32'h00003030, 32'h0, 32'h0, 32'h55AA55AA, 32'h0, 5'd4, 5'd3);
    expect_val(c_F_RT, 32'h55AA55AA, "lw_byp");
    expect_write(1'b1, 5'd3, 32'h55AA55AA, "lw");
    expect_retire("lw");
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      apply(32'd0, 32'h0000FFF0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3);
      expect_val(c_F_RT, 32'h55AA55AA, "lw_reg");
      expect_write(1'b0, 5'd0, 32'd0, "nop");
      expect_retire("nop");
      next_cycle();
    end

    // ori $5: both ports bypass at once.
    apply(32'h34050077, 32'h00003034, 32'h77, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5);
    expect_val(c_F_RS, 32'h77, "dual_byp_rs");
    expect_val(c_F_RT, 32'h77, "dual_byp_rt");
    next_cycle();

    // ori $0,$0,5: no write, $0 still zero.
    apply(32'h34000005, 32'h00003038, 32'h5, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5);
    expect_val(c_F_RS, 32'd0, "ori0_rs");
    expect_val(c_F_RT, 32'h77, "ori5_reg");
    expect_write(1'b0, 5'd0, 32'd0, "ori0");
    expect_retire("ori0");
    next_cycle();

    // Mid-cycle asynchronous reset while ori $6 is in W.
    apply(32'h34060099, 32'h0000303C, 32'h99, 32'h0, 32'h0, 32'h0, 5'd1, 5'd3);
    #2;
    reset = 1'b0;
    #1;
    m_rc = 32'd0; m_lpc = 32'h00003000; prev_instr = 32'd0;
    expect_val(c_F_RS, 32'd0, "async_rs");
    expect_val(c_F_RT, 32'd0, "async_rt");
    expect_write(1'b0, 5'd0, 32'd0, "async");
    expect_retire("async");
    ->ev_sample;
    next_cycle();
    prev_instr = 32'd0;

    // Release reset with ori $7 already presented: taken on the next edge.
    reset = 1'b1;
    apply(32'h34070042, 32'h00003040, 32'h42, 32'h0, 32'h0, 32'h0, 5'd6, 5'd1);
    expect_val(c_F_RS, 32'd0, "dropped_r6");
    expect_val(c_F_RT, 32'd0, "cleared_r1");
    expect_retire("deassert");
    next_cycle();
    apply(32'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd6);
    expect_val(c_F_RS, 32'h42, "first_write_r7");
    expect_val(c_F_RT, 32'd0, "dropped_r6_again");
    expect_retire("first_write");
    next_cycle();

    @(negedge clk);
    #1;
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_grf_writeback.md
Name: wb_grf_writeback

Overview:
- Consumer end of the M→W pipeline register: takes the W-stage bundle (instruction, PC, ALU/EXT/memory/byte results) and writes the selected result into the 32×32 general register file.
- Provides the two D-stage read ports, with same-cycle W→D bypass.
- Exports the W-stage write triple to the forwarding/hazard unit.
- Keeps a retired-instruction counter.

Parameters:
- PC_RESET, 32'h00003000, reset value of the last-retired-PC register.
- NUM_REGS, 32, register count; address width is fixed at 5, and $0 is hardwired to zero.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- W_Instr  in  32  W-stage instruction; 32'h0 is a nop.
- W_PC  in  32  W-stage instruction address.
- W_ALUResult  in  32  ALU result.
- W_EXTResult  in  32  immediate-extend result (lui path).
- W_MemReadData  in  32  word loaded by lw.
- W_ReadByteData  in  32  sign-extended byte loaded by lb.
- D_RsAddr  in  5  read port 1 address.
- D_RtAddr  in  5  read port 2 address.
- D_RsData  out  32  read port 1 data.
- D_RtData  out  32  read port 2 data.
- W_WriteEn  out  1  W stage writes a nonzero register this cycle.
- W_WriteAddr  out  5  destination register; 0 when there is no write.
- W_WriteData  out  32  data being written.
- RetireCount  out  32  number of non-nop instructions retired.
- LastPC  out  32  PC of the most recently retired non-nop instruction.

Behaviour:
- Decode, combinational, from W_Instr:
  - opcode 0 with funct 0x21 (addu) or 0x23 (subu): dest = rd, data = W_ALUResult.
  - ori (0x0d): dest = rt, data = W_ALUResult.
  - lui (0x0f): dest = rt, data = W_EXTResult.
  - lw (0x23): dest = rt, data = W_MemReadData.
  - lb (0x20): dest = rt, data = W_ReadByteData.
  - jal (0x03): dest = 31, data = W_PC + 8, with 32-bit wrap.
  - All other instructions (sw, beq, jr, nop, unknown): no write, dest = 0, data = 0.
- W_WriteEn = decoded write AND dest != 0.
  - W_WriteAddr and W_WriteData are forced to 0 when W_WriteEn = 0.
- Register write: on posedge clk with reset high and W_WriteEn = 1, regs[W_WriteAddr] <= W_WriteData. One write per cycle; latency is one edge.
- $0: never written; it always reads 0, including when W_Instr targets $0 (e.g. ori $0,$0,5).
- Read ports are combinational:
  - Address 0 → 0.
  - Address equal to W_WriteAddr while W_WriteEn = 1 → W_WriteData (bypass; new value visible in the same cycle).
  - Otherwise → regs[address].
  - Both ports may bypass simultaneously.
- Retire tracking: on posedge with reset high and W_Instr != 0, RetireCount <= RetireCount + 1 (wraps from 32'hFFFFFFFF to 0) and LastPC <= W_PC.
  - Nops do not change either register.
- Reset (reset = 0), asynchronous and taking effect immediately without waiting for clk:
  - All regs = 0, RetireCount = 0, LastPC = PC_RESET.
  - While reset is low, D_RsData = D_RtData = 0 and W_WriteEn = 0. No write occurs on any edge while reset is low.
- Reset mid-operation: a write presented in the same cycle that reset asserts is discarded.
- Deassertion: the first write is taken on the first rising edge after reset returns high.

Optional Feature:
- GRF_TRACE_EN: when defined, every committed register write executes $display("@%h: $%d <= %h", W_PC, W_WriteAddr, W_WriteData) at that clock edge.
  - Writes to $0 and cycles with reset low print nothing.
- When undefined: no simulation output and identical functional behaviour.

Test Plan:
- Reset low for 2 cycles then high → all 32 regs read 0, RetireCount = 0, LastPC = 32'h00003000. Asserting reset asynchronously mid-cycle zeroes the read outputs immediately.
- ori $1,$0,0x1234 (W_Instr 32'h34011234, W_ALUResult 32'h1234) for one cycle, D_RsAddr = 1:
  - Same cycle: D_RsData = 32'h1234 via bypass, W_WriteEn = 1, W_WriteAddr = 1.
  - After the edge: regs[1] = 32'h1234, RetireCount = 1.
- jal at W_PC = 32'h00003010 (W_Instr 32'h0C000C08) → regs[31] = 32'h00003018.
  - lb to $2 with W_ReadByteData = 32'hFFFFFF80 → regs[2] = 32'hFFFFFF80.
- Write to $0: addu with rd = 0, W_ALUResult = 32'hDEADBEEF → W_WriteEn = 0 and $0 still reads 0. sw and beq instructions produce no register change, but RetireCount increments for each.
- Back-to-back lui $3 (W_EXTResult 32'hABCD0000) then lw $3 (W_MemReadData 32'h55AA55AA) with D_RtAddr = 3:
  - D_RtData tracks each new value in its own W cycle.
  - Final regs[3] = 32'h55AA55AA.
  - Nop cycles in between leave RetireCount and LastPC unchanged.
- With GRF_TRACE_EN defined, run the ori case above → exactly one line is printed: "@00003000: $ 1 <= 00001234".
